instruction_buffer: RTL and testbench
=====================================

# instruction_buffer

- Circular buffer between the 4-wide fetch/decode stage and dispatch.
- Each cycle it accepts 0–4 decoded instructions with their operand-dependency tags, in program order.
- Each cycle it presents up to 4 oldest entries to dispatch and retires however many dispatch consumes.
- It reports free capacity back to fetch as `num_fetch`, and is flushed on a taken jump.

## Interface
- `DEPTH`, default 8: entry count. Power of two, ≥ 4.
- `clk` input, 1: clock, rising-edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `flush` input, 1: discard all entries. Driven by the branch unit's `is_jump`.
- `in_count` input, 3: number of valid input lanes (0–4), lanes 0..in_count-1, lane 0 oldest.
- `opcode_in[0:3]`, `rt_in[0:3]`, `ra_in[0:3]`, `rb_in[0:3]` input, 4 each: decoded fields per lane.
- `op_a_local_dep_in[0:3]`, `op_b_local_dep_in[0:3]` input, 1 each: local-dependency flags per lane.
- `op_a_owner_in[0:3]`, `op_b_owner_in[0:3]` input, 4 each: ROB owner tags per lane.
- `num_fetch` output, 3: free slots to fetch, min(4, DEPTH − count).
- `out_valid` output, 4: thermometer code; bit i set iff count > i.
- `opcode_out[0:3]`, `rt_out[0:3]`, `ra_out[0:3]`, `rb_out[0:3]`, `op_a_local_dep_out[0:3]`, `op_a_owner_out[0:3]`, `op_b_local_dep_out[0:3]`, `op_b_owner_out[0:3]` output: entry at head+i, lane 0 oldest.
- `deq_count` input, 3: entries consumed by dispatch this cycle (0–4).
- `overflow` output, 1: one-cycle pulse; the enqueue was rejected this edge.

## Operation
- State:
  - storage of DEPTH × 26-bit entries;
  - `head`, `tail`: log2(DEPTH) bits, wrapping modulo DEPTH;
  - `count`: log2(DEPTH)+1 bits.
- `num_fetch`, `out_valid` and all `*_out` are combinational from registered state only.
- Output lanes with `out_valid[i]`=0 drive all-zero fields.
- Effective dequeue: `deq_eff` = min(`deq_count`, count).
- Enqueue legality: `in_count` ≤ `num_fetch`.
  - Capacity is judged before the same-cycle dequeue; same-cycle dequeue never creates room.
  - If illegal: nothing is written, tail is unchanged, and `overflow` pulses next cycle.
  - Dequeue still proceeds on an illegal-enqueue edge.
- Legal enqueue: lane i is written to storage[tail+i mod DEPTH] for i < `in_count`; tail += `in_count`.
- Dequeue: head += `deq_eff`.
- Count update: count ← count + in_eff − `deq_eff`, where in_eff = `in_count` if legal, else 0.
- Flush has priority over everything:
  - head, tail, count ← 0; `overflow` ← 0;
  - input lanes and `deq_count` are ignored that edge;
  - storage contents need not be cleared.
- `in_count` > 4 is treated as 0 (no write, no overflow).
- Storage holds all fields verbatim; it performs no recomputation of dependency tags.

## Timing
- Reset (`rst_n` low, asynchronous): head=tail=count=0, `out_valid`=0, `num_fetch`=4, `overflow`=0, all `*_out`=0.
  - Deassertion is sampled at the next rising edge.
  - Reset mid-operation drops all entries immediately, without waiting for a clock.
- Enqueue→visible latency is 1 cycle: data written at edge N appears on `*_out`/`out_valid` after edge N.
- Buffer is never bypassed: on an empty buffer, an input lane is not visible at the output in the same cycle.
- Dequeue effect is visible after the edge. Dispatch samples `*_out` in the same cycle it asserts `deq_count`.
- Full: count=DEPTH gives `num_fetch`=0; any `in_count` > 0 then overflows.
- Empty: `out_valid`=0, `deq_eff`=0, head is unchanged.
- Wrap-around: a single 4-lane enqueue or dequeue may straddle index DEPTH−1→0 and must remain in order.
- Simultaneous legal enqueue and dequeue on the same edge are both applied.
- `num_fetch` is 4 whenever DEPTH − count ≥ 4.

## Test plan
- Reset then idle:
  - `rst_n` low mid-run with count=5 → immediately count=0, `out_valid`=0000, `num_fetch`=4, `overflow`=0.
- Basic fill and drain:
  - enqueue 4 (opcodes 1,2,3,4), deq 0 → next cycle `out_valid`=1111, `opcode_out`=1,2,3,4, `num_fetch`=4;
  - enqueue 4 more (5–8) → `num_fetch`=0;
  - deq 4 → `opcode_out`=5,6,7,8.
- Overflow:
  - count=6 (DEPTH=8, `num_fetch`=2), `in_count`=3 with `deq_count`=2 → no write, `overflow`=1 one cycle, count=4, `out_valid`=1111.
- Wrap-around:
  - advance head/tail to 6; enqueue 4 (opcodes 9–12) → stored at 6,7,0,1;
  - `opcode_out`=9,10,11,12 in order;
  - owner tags and local-dep bits are preserved per lane.
- Flush priority:
  - count=5, assert `flush` with `in_count`=4 and `deq_count`=2 → next cycle count=0, `out_valid`=0000, `num_fetch`=4.
- Dequeue clamp and mixed traffic:
  - count=2, `deq_count`=4, `in_count`=3 → count=3, `out_valid`=0111, and outputs are the 3 newly enqueued entries in order.

Source files
------------

// File: rtl/instruction_buffer_if.sv
// Purpose: fetch/dispatch side bundle of the 4-lane instruction buffer.
// Latency: n/a (wiring only).
// Backpressure: fetch honours num_fetch; dispatch consumes via deq_count.
interface instruction_buffer_if;
   // fetch / decode side
   logic       flush;
   logic [2:0] in_count;
   logic [3:0] opcode_in          [0:3];
   logic [3:0] rt_in              [0:3];
   logic [3:0] ra_in              [0:3];
   logic [3:0] rb_in              [0:3];
   logic       op_a_local_dep_in  [0:3];
   logic       op_b_local_dep_in  [0:3];
   logic [3:0] op_a_owner_in      [0:3];
   logic [3:0] op_b_owner_in      [0:3];
   logic [2:0] num_fetch;
   logic       overflow;

   // dispatch side
   logic [3:0] out_valid;
   logic [3:0] opcode_out         [0:3];
   logic [3:0] rt_out             [0:3];
   logic [3:0] ra_out             [0:3];
   logic [3:0] rb_out             [0:3];
   logic       op_a_local_dep_out [0:3];
   logic [3:0] op_a_owner_out     [0:3];
   logic       op_b_local_dep_out [0:3];
   logic [3:0] op_b_owner_out     [0:3];
   logic [2:0] deq_count;

   modport master (
      output flush, in_count, opcode_in, rt_in, ra_in, rb_in,
             op_a_local_dep_in, op_b_local_dep_in, op_a_owner_in, op_b_owner_in,
             deq_count,
      input  num_fetch, overflow, out_valid, opcode_out, rt_out, ra_out, rb_out,
             op_a_local_dep_out, op_a_owner_out, op_b_local_dep_out, op_b_owner_out
   );

   modport slave (
      input  flush, in_count, opcode_in, rt_in, ra_in, rb_in,
             op_a_local_dep_in, op_b_local_dep_in, op_a_owner_in, op_b_owner_in,
             deq_count,
      output num_fetch, overflow, out_valid, opcode_out, rt_out, ra_out, rb_out,
             op_a_local_dep_out, op_a_owner_out, op_b_local_dep_out, op_b_owner_out
   );
endinterface

// File: rtl/instruction_buffer.sv
// Purpose: circular buffer of decoded instructions between 4-wide fetch and dispatch.
// Latency: 1 cycle enqueue-to-visible, never bypassed; outputs come from registered state only.
// Backpressure: num_fetch advertises free slots; an enqueue larger than that is dropped whole and flagged on overflow.
module instruction_buffer #(
   parameter int DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   instruction_buffer_if.slave ib
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [3:0] opcode;
      logic [3:0] rt;
      logic [3:0] ra;
      logic [3:0] rb;
      logic       a_dep;
      logic [3:0] a_owner;
      logic       b_dep;
      logic [3:0] b_owner;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] count;
   logic          overflow_q;

   logic [CW-1:0] free_slots;
   logic [2:0]    num_fetch_c;
   logic          enq_ok;
   logic          enq_reject;
   logic [2:0]    in_eff;
   logic [CW-1:0] deq_ext;
   logic [CW-1:0] deq_eff;
   logic [3:0]    out_valid_c;
   entry_t        in_ent  [4];
   entry_t        out_ent [4];

   // Capacity is judged on the pre-edge count, so a same-cycle dequeue never makes room.
   // in_count > 4 always exceeds num_fetch, so it writes nothing, yet it is not flagged.
   always_comb begin
      free_slots  = CW'(DEPTH) - count;
      num_fetch_c = (free_slots >= CW'(4)) ? 3'd4 : free_slots[2:0];
      enq_ok      = (ib.in_count <= num_fetch_c);
      enq_reject  = !enq_ok && (ib.in_count <= 3'd4);
      in_eff      = enq_ok ? ib.in_count : 3'd0;
      deq_ext     = CW'(ib.deq_count);
      deq_eff     = (deq_ext > count) ? count : deq_ext;
   end

   // Pack the per-lane input fields into storage entries.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         in_ent[i].opcode  = ib.opcode_in[i];
         in_ent[i].rt      = ib.rt_in[i];
         in_ent[i].ra      = ib.ra_in[i];
         in_ent[i].rb      = ib.rb_in[i];
         in_ent[i].a_dep   = ib.op_a_local_dep_in[i];
         in_ent[i].a_owner = ib.op_a_owner_in[i];
         in_ent[i].b_dep   = ib.op_b_local_dep_in[i];
         in_ent[i].b_owner = ib.op_b_owner_in[i];
      end
   end

   // Present the four oldest entries; lanes past count read as zero.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         out_valid_c[i] = (count > CW'(i));
         out_ent[i]     = out_valid_c[i] ? mem[head + AW'(i)] : '0;
         ib.opcode_out[i]         = out_ent[i].opcode;
         ib.rt_out[i]             = out_ent[i].rt;
         ib.ra_out[i]             = out_ent[i].ra;
         ib.rb_out[i]             = out_ent[i].rb;
         ib.op_a_local_dep_out[i] = out_ent[i].a_dep;
         ib.op_a_owner_out[i]     = out_ent[i].a_owner;
         ib.op_b_local_dep_out[i] = out_ent[i].b_dep;
         ib.op_b_owner_out[i]     = out_ent[i].b_owner;
      end
      ib.out_valid = out_valid_c;
      ib.num_fetch = num_fetch_c;
      ib.overflow  = overflow_q;
   end

   // Pointer, occupancy and overflow-pulse update; flush overrides both enqueue and dequeue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else if (ib.flush) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         head       <= head + AW'(deq_eff);
         tail       <= tail + AW'(in_eff);
         count      <= count + CW'(in_eff) - deq_eff;
         overflow_q <= enq_reject;
      end
   end

   // Write accepted lanes at tail onward; the pointer add wraps naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (!ib.flush && enq_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (3'(i) < ib.in_count) begin
               mem[tail + AW'(i)] <= in_ent[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_instruction_buffer.sv
// Purpose: self-checking bench for instruction_buffer against a queue-based reference model.
// Latency: expects 1-cycle enqueue-to-visible and immediate async reset.
// Backpressure: exercises full, overflow, dequeue clamp and flush priority.
module tb_instruction_buffer;
   localparam int DEPTH = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instruction_buffer_if ib ();

   instruction_buffer #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ib    (ib)
   );

   typedef struct packed {
      logic [3:0] opc;
      logic [3:0] rt;
      logic [3:0] ra;
      logic [3:0] rb;
      logic       adep;
      logic [3:0] aown;
      logic       bdep;
      logic [3:0] bown;
   } ent_t;

   ent_t mq[$];          // reference contents, front = oldest
   logic m_ovf = 1'b0;   // reference overflow pulse
   ent_t stim [4];
   ent_t saved [4];
   int   chk  = 0;
   int   errs = 0;

   function automatic ent_t rand_ent();
      logic [31:0] r;
      r = $urandom;
      return r[25:0];
   endfunction

   function automatic ent_t dut_lane(input int i);
      ent_t e;
      e.opc  = ib.opcode_out[i];
      e.rt   = ib.rt_out[i];
      e.ra   = ib.ra_out[i];
      e.rb   = ib.rb_out[i];
      e.adep = ib.op_a_local_dep_out[i];
      e.aown = ib.op_a_owner_out[i];
      e.bdep = ib.op_b_local_dep_out[i];
      e.bown = ib.op_b_owner_out[i];
      return e;
   endfunction

   function automatic logic [3:0] exp_valid();
      int s;
      s = (mq.size() > 4) ? 4 : mq.size();
      return 4'((1 << s) - 1);
   endfunction

   function automatic logic [2:0] exp_fetch();
      int f;
      f = DEPTH - mq.size();
      return 3'((f > 4) ? 4 : f);
   endfunction

   function automatic ent_t exp_lane(input int i);
      return (i < mq.size()) ? mq[i] : ent_t'(0);
   endfunction

   task automatic set_ops(input int base);
      for (int i = 0; i < 4; i++) begin
         stim[i]     = rand_ent();
         stim[i].opc = 4'(base + i);
      end
   endtask

   task automatic drive(input int n, input int d, input bit fl);
      ib.in_count  = 3'(n);
      ib.deq_count = 3'(d);
      ib.flush     = fl;
      for (int i = 0; i < 4; i++) begin
         ib.opcode_in[i]         = stim[i].opc;
         ib.rt_in[i]             = stim[i].rt;
         ib.ra_in[i]             = stim[i].ra;
         ib.rb_in[i]             = stim[i].rb;
         ib.op_a_local_dep_in[i] = stim[i].adep;
         ib.op_a_owner_in[i]     = stim[i].aown;
         ib.op_b_local_dep_in[i] = stim[i].bdep;
         ib.op_b_owner_in[i]     = stim[i].bown;
      end
   endtask

   // Reference behaviour for one clock edge, straight from the buffer rules.
   function automatic void model_step(input int n, input int d, input bit fl);
      int  nn, cap, de;
      bit  legal;
      if (fl) begin
         mq.delete();
         m_ovf = 1'b0;
         return;
      end
      nn    = (n > 4) ? 0 : n;
      cap   = DEPTH - mq.size();
      if (cap > 4) cap = 4;
      legal = (nn <= cap);
      de    = (d < mq.size()) ? d : mq.size();
      repeat (de) void'(mq.pop_front());
      if (legal) for (int i = 0; i < nn; i++) mq.push_back(stim[i]);
      m_ovf = !legal;
   endfunction

   // One clock: hold inputs across the edge, update the model, sample 1 time unit later.
   task automatic apply(input int n, input int d, input bit fl);
      drive(n, d, fl);
      @(posedge clk);
      model_step(n, d, fl);
      #1;
      drive(0, 0, 1'b0);
   endtask

   task automatic test_reset();
      drive(0, 0, 1'b0);
      #2;
      chk++; if (ib.out_valid !== 4'b0000) begin errs++; $display("FAIL rst_valid got %b exp 0000", ib.out_valid); end
      chk++; if (ib.num_fetch !== 3'd4) begin errs++; $display("FAIL rst_fetch got %0d exp 4", ib.num_fetch); end
      chk++; if (ib.overflow !== 1'b0) begin errs++; $display("FAIL rst_ovf got %b exp 0", ib.overflow); end
      @(negedge clk);
      rst_n = 1'b1;
      set_ops(1); apply(4, 0, 1'b0);
      set_ops(5); apply(1, 0, 1'b0);
      apply(4, 0, 1'b0);   // count 5, only 3 free: rejected
      chk++; if (ib.out_valid !== 4'b1111 || ib.num_fetch !== 3'd3 || ib.overflow !== 1'b1) begin
         errs++; $display("FAIL pre_rst got valid=%b fetch=%0d ovf=%b exp 1111/3/1", ib.out_valid, ib.num_fetch, ib.overflow);
      end
      #2;
      rst_n = 1'b0;
      mq.delete(); m_ovf = 1'b0;
      #1;
      chk++; if (ib.out_valid !== 4'b0000) begin errs++; $display("FAIL async_rst_valid got %b exp 0000", ib.out_valid); end
      chk++; if (ib.num_fetch !== 3'd4) begin errs++; $display("FAIL async_rst_fetch got %0d exp 4", ib.num_fetch); end
      chk++; if (ib.overflow !== 1'b0) begin errs++; $display("FAIL async_rst_ovf got %b exp 0", ib.overflow); end
      chk++; if (dut_lane(0) !== ent_t'(0)) begin errs++; $display("FAIL async_rst_lane0 got %h exp 0", dut_lane(0)); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_fill_drain();
      set_ops(1);
      drive(4, 0, 1'b0);
      #1;
      chk++; if (ib.out_valid !== 4'b0000) begin errs++; $display("FAIL no_bypass got %b exp 0000", ib.out_valid); end
      apply(4, 0, 1'b0);
      chk++; if (ib.out_valid !== 4'b1111) begin errs++; $display("FAIL fill_valid got %b exp 1111", ib.out_valid); end
      chk++; if (ib.num_fetch !== 3'd4) begin errs++; $display("FAIL fill_fetch got %0d exp 4", ib.num_fetch); end
      for (int i = 0; i < 4; i++) begin
         chk++; if (ib.opcode_out[i] !== 4'(1 + i)) begin errs++; $display("FAIL fill_op%0d got %0d exp %0d", i, ib.opcode_out[i], 1 + i); end
      end
      set_ops(5); apply(4, 0, 1'b0);
      chk++; if (ib.num_fetch !== 3'd0) begin errs++; $display("FAIL full_fetch got %0d exp 0", ib.num_fetch); end
      set_ops(13); apply(1, 4, 1'b0);   // full: rejected, dequeue still happens
      chk++; if (ib.overflow !== 1'b1) begin errs++; $display("FAIL full_ovf got %b exp 1", ib.overflow); end
      chk++; if (ib.num_fetch !== 3'd4) begin errs++; $display("FAIL drain_fetch got %0d exp 4", ib.num_fetch); end
      for (int i = 0; i < 4; i++) begin
         chk++; if (ib.opcode_out[i] !== 4'(5 + i)) begin errs++; $display("FAIL drain_op%0d got %0d exp %0d", i, ib.opcode_out[i], 5 + i); end
      end
      apply(0, 0, 1'b0);
      chk++; if (ib.overflow !== 1'b0) begin errs++; $display("FAIL ovf_pulse got %b exp 0", ib.overflow); end
      apply(0, 4, 1'b0);
      chk++; if (ib.out_valid !== 4'b0000) begin errs++; $display("FAIL empty_valid got %b exp 0000", ib.out_valid); end
   endtask

   task automatic test_overflow();
      set_ops(1); apply(4, 0, 1'b0);
      set_ops(5); apply(2, 0, 1'b0);
      chk++; if (ib.num_fetch !== 3'd2) begin errs++; $display("FAIL ovf_pre_fetch got %0d exp 2", ib.num_fetch); end
      set_ops(10); apply(3, 2, 1'b0);
      chk++; if (ib.overflow !== 1'b1) begin errs++; $display("FAIL ovf_flag got %b exp 1", ib.overflow); end
      chk++; if (ib.out_valid !== 4'b1111 || ib.num_fetch !== 3'd4) begin
         errs++; $display("FAIL ovf_count got valid=%b fetch=%0d exp 1111/4", ib.out_valid, ib.num_fetch);
      end
      for (int i = 0; i < 4; i++) begin
         chk++; if (ib.opcode_out[i] !== 4'(3 + i)) begin errs++; $display("FAIL ovf_op%0d got %0d exp %0d", i, ib.opcode_out[i], 3 + i); end
      end
      apply(0, 0, 1'b0);
      chk++; if (ib.overflow !== 1'b0) begin errs++; $display("FAIL ovf_clear got %b exp 0", ib.overflow); end
      apply(0, 4, 1'b0);   // head and tail now both at 6
   endtask

   task automatic test_wrap();
      set_ops(9);
      for (int i = 0; i < 4; i++) saved[i] = stim[i];
      apply(4, 0, 1'b0);   // occupies slots 6,7,0,1
      for (int i = 0; i < 4; i++) begin
         chk++; if (ib.opcode_out[i] !== 4'(9 + i)) begin errs++; $display("FAIL wrap_op%0d got %0d exp %0d", i, ib.opcode_out[i], 9 + i); end
         chk++; if (dut_lane(i) !== saved[i]) begin errs++; $display("FAIL wrap_lane%0d got %h exp %h", i, dut_lane(i), saved[i]); end
      end
      apply(0, 2, 1'b0);
      chk++; if (ib.out_valid !== 4'b0011) begin errs++; $display("FAIL wrap_deq_valid got %b exp 0011", ib.out_valid); end
      chk++; if (dut_lane(0) !== saved[2] || dut_lane(1) !== saved[3]) begin
         errs++; $display("FAIL wrap_deq_lanes got %h %h exp %h %h", dut_lane(0), dut_lane(1), saved[2], saved[3]);
      end
      apply(0, 2, 1'b0);
   endtask

   task automatic test_flush();
      set_ops(1); apply(4, 0, 1'b0);
      apply(1, 0, 1'b0);
      set_ops(7); apply(4, 2, 1'b1);
      chk++; if (ib.out_valid !== 4'b0000 || ib.num_fetch !== 3'd4) begin
         errs++; $display("FAIL flush_state got valid=%b fetch=%0d exp 0000/4", ib.out_valid, ib.num_fetch);
      end
      apply(4, 0, 1'b0);
      apply(4, 0, 1'b0);
      apply(4, 0, 1'b1);   // full and over-requesting, but flush wins
      chk++; if (ib.overflow !== 1'b0 || ib.out_valid !== 4'b0000) begin
         errs++; $display("FAIL flush_full got ovf=%b valid=%b exp 0/0000", ib.overflow, ib.out_valid);
      end
   endtask

   task automatic test_clamp_mixed();
      set_ops(1); apply(2, 0, 1'b0);
      set_ops(12);
      for (int i = 0; i < 4; i++) saved[i] = stim[i];
      apply(3, 4, 1'b0);
      chk++; if (ib.out_valid !== 4'b0111) begin errs++; $display("FAIL clamp_valid got %b exp 0111", ib.out_valid); end
      for (int i = 0; i < 3; i++) begin
         chk++; if (dut_lane(i) !== saved[i]) begin errs++; $display("FAIL clamp_lane%0d got %h exp %h", i, dut_lane(i), saved[i]); end
      end
      chk++; if (dut_lane(3) !== ent_t'(0)) begin errs++; $display("FAIL clamp_lane3 got %h exp 0", dut_lane(3)); end
      apply(0, 4, 1'b0);
   endtask

   task automatic test_in_count_gt4();
      set_ops(2); apply(7, 0, 1'b0);
      chk++; if (ib.out_valid !== 4'b0000 || ib.overflow !== 1'b0) begin
         errs++; $display("FAIL gt4_empty got valid=%b ovf=%b exp 0000/0", ib.out_valid, ib.overflow);
      end
      apply(2, 0, 1'b0);
      apply(5, 0, 1'b0);
      chk++; if (ib.out_valid !== 4'b0011 || ib.overflow !== 1'b0) begin
         errs++; $display("FAIL gt4_partial got valid=%b ovf=%b exp 0011/0", ib.out_valid, ib.overflow);
      end
      apply(0, 4, 1'b0);
   endtask

   task automatic test_random();
      int n, d;
      bit fl;
      for (int it = 0; it < 400; it++) begin
         for (int i = 0; i < 4; i++) stim[i] = rand_ent();
         n  = ($urandom_range(0, 24) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
         d  = int'($urandom_range(0, 4));
         if ($urandom_range(0, 2) == 0) d = 0;
         fl = ($urandom_range(0, 39) == 0);
         apply(n, d, fl);
         chk++; if (ib.out_valid !== exp_valid()) begin errs++; $display("FAIL rnd%0d_valid got %b exp %b", it, ib.out_valid, exp_valid()); end
         chk++; if (ib.num_fetch !== exp_fetch()) begin errs++; $display("FAIL rnd%0d_fetch got %0d exp %0d", it, ib.num_fetch, exp_fetch()); end
         chk++; if (ib.overflow !== m_ovf) begin errs++; $display("FAIL rnd%0d_ovf got %b exp %b", it, ib.overflow, m_ovf); end
         for (int i = 0; i < 4; i++) begin
            chk++; if (dut_lane(i) !== exp_lane(i)) begin errs++; $display("FAIL rnd%0d_lane%0d got %h exp %h", it, i, dut_lane(i), exp_lane(i)); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_wrap();
      test_flush();
      test_clamp_mixed();
      test_in_count_gt4();
      test_random();
      $display("CHECKS %0d ERRORS %0d", chk, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
